mips16_core: RTL and testbench

//  Single-cycle 16-bit MIPS-style processor: 32-bit instructions, 16x16-bit register file, 16-bit ALU/PC.
//  Top of the mips16 project; the bench preloads instruction ROM and observes PC, instruction, ALU result.
//  One instruction completes per rising clock edge.

---
 rtl/mips16_pkg.sv | 65 ++++++
 rtl/mips16_if.sv | 21 ++
 rtl/mips16_inst_mem.sv | 23 ++
 rtl/mips16_reg_file.sv | 27 ++
 rtl/mips16_core.sv | 142 ++++++++++++++
 tb/tb_mips16_core.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/mips16_pkg.sv
// Shared encodings for the mips16 core: opcodes, function codes, ALU operations and field positions.
// The optional multiplier (funct 0x18) is enabled by defining MIPS16_MUL_EN.
package mips16_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 22;
  localparam int RT_MSB  = 21;
  localparam int RT_LSB  = 18;
  localparam int RD_MSB  = 17;
  localparam int RD_LSB  = 14;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    b_imm;
    logic    reg_we;
    logic    dst_rd;
    logic    mem_we;
    logic    mem_rd;
    logic    beq;
    logic    bne;
    logic    jump;
  } ctrl_t;

endpackage

// File: rtl/mips16_if.sv
// Side-band bus of the mips16 core: instruction ROM load port (master drives) and
// writeback/store trace (core drives). Valid/ready is not used: load_we qualifies one ROM word per rising edge.
interface mips16_if;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        mem_we;

  modport master (
    output load_we, load_addr, load_data,
    input  reg_we, reg_waddr, reg_wdata, mem_we
  );

  modport slave (
    input  load_we, load_addr, load_data,
    output reg_we, reg_waddr, reg_wdata, mem_we
  );
endinterface

// File: rtl/mips16_inst_mem.sv
// Instruction ROM: combinational read by word index; the load port only fills it before execution.
module mips16_inst_mem
  import mips16_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] rom [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) rom[waddr_i] <= wdata_i;
  end

  assign rdata_o = rom[raddr_i];

endmodule

// File: rtl/mips16_reg_file.sv
// 16 x 16-bit register file: two combinational read ports, one write port; r0 is hardwired to zero.
module mips16_reg_file (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  ra1_i,
  input  logic [3:0]  ra2_i,
  output logic [15:0] rd1_o,
  output logic [15:0] rd2_o,
  input  logic        we_i,
  input  logic [3:0]  wa_i,
  input  logic [15:0] wd_i
);

  logic [15:0] reg_array [0:15];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) reg_array[i] <= '0;
    end else if (we_i && (wa_i != 4'd0)) begin
      reg_array[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 4'd0) ? 16'd0 : reg_array[ra1_i];
  assign rd2_o = (ra2_i == 4'd0) ? 16'd0 : reg_array[ra2_i];

endmodule

// File: rtl/mips16_core.sv
// Single-cycle 16-bit MIPS-style core: decode, ALU, data RAM and PC logic; one instruction per rising edge.
// Define MIPS16_MUL_EN to add the R-type mul (funct 0x18); otherwise that funct is a NOP.
module mips16_core
  import mips16_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] pc_out,
  output logic [15:0] alu_result,
  output logic [31:0] instr_out,
  mips16_if.slave     bus
);

  logic [15:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [3:0]  rs, rt, rd, wa;
  logic [15:0] imm, rs_val, rt_val, alu_b, alu_y, wd;
  logic        zero, taken;
  ctrl_t       ctrl;
  logic [15:0] dmem_q [0:DMEM_DEPTH-1];

  mips16_inst_mem inst_mem (
    .clk_i   (clock),
    .we_i    (bus.load_we),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_q[9:2]),
    .rdata_o (instr)
  );

  assign op    = instr[OP_MSB:OP_LSB];
  assign rs    = instr[RS_MSB:RS_LSB];
  assign rt    = instr[RT_MSB:RT_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];
  assign funct = instr[FN_MSB:FN_LSB];
  assign imm   = instr[IMM_MSB:IMM_LSB];

  mips16_reg_file reg_file (
    .clk_i  (clock),
    .rst_ni (reset),
    .ra1_i  (rs),
    .ra2_i  (rt),
    .rd1_o  (rs_val),
    .rd2_o  (rt_val),
    .we_i   (ctrl.reg_we),
    .wa_i   (wa),
    .wd_i   (wd)
  );

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.dst_rd = 1'b1;
        ctrl.reg_we = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
`ifdef MIPS16_MUL_EN
          FN_MUL:  ctrl.alu_op = ALU_MUL;
`endif
          default: ctrl.reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin ctrl.alu_op = ALU_ADD; ctrl.b_imm = 1'b1; ctrl.reg_we = 1'b1; end
      OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.b_imm = 1'b1; ctrl.reg_we = 1'b1; end
      OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.b_imm = 1'b1; ctrl.reg_we = 1'b1; end
      OP_SLTI: begin ctrl.alu_op = ALU_SLT; ctrl.b_imm = 1'b1; ctrl.reg_we = 1'b1; end
      OP_LW: begin
        ctrl.alu_op = ALU_ADD; ctrl.b_imm = 1'b1; ctrl.reg_we = 1'b1; ctrl.mem_rd = 1'b1;
      end
      OP_SW:   begin ctrl.alu_op = ALU_ADD; ctrl.b_imm = 1'b1; ctrl.mem_we = 1'b1; end
      OP_BEQ:  begin ctrl.alu_op = ALU_SUB; ctrl.beq = 1'b1; end
      OP_BNE:  begin ctrl.alu_op = ALU_SUB; ctrl.bne = 1'b1; end
      OP_J:    ctrl.jump = 1'b1;
      default: ;
    endcase
  end

  // Immediates are already 16 bits wide, so sign- and zero-extension are the same wire.
  assign alu_b = ctrl.b_imm ? imm : rt_val;

  always_comb begin
    alu_y = '0;
    case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_XOR: alu_y = rs_val ^ alu_b;
      ALU_NOR: alu_y = ~(rs_val | alu_b);
      ALU_SLT: alu_y = {15'd0, $signed(rs_val) < $signed(alu_b)};
`ifdef MIPS16_MUL_EN
      // Low half of a product is identical for signed and unsigned operands.
      ALU_MUL: alu_y = rs_val * alu_b;
`endif
      default: alu_y = '0;
    endcase
  end

  assign zero     = (alu_y == 16'd0);
  assign taken    = (ctrl.beq && zero) || (ctrl.bne && !zero);
  assign pc_plus4 = pc_q + 16'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump)  pc_d = {imm[13:0], 2'b00};
    else if (taken) pc_d = pc_plus4 + {imm[13:0], 2'b00};
  end

  assign wa = ctrl.dst_rd ? rd : rt;
  assign wd = ctrl.mem_rd ? dmem_q[alu_y[7:0]] : alu_y;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else if (ctrl.mem_we) begin
      dmem_q[alu_y[7:0]] <= rt_val;
    end
  end

  assign pc_out     = pc_q;
  assign alu_result = alu_y;
  assign instr_out  = instr;

  assign bus.reg_we    = ctrl.reg_we;
  assign bus.reg_waddr = wa;
  assign bus.reg_wdata = wd;
  assign bus.mem_we    = ctrl.mem_we;

endmodule

// File: tb/tb_mips16_core.sv
// Bench for mips16_core: directed program with fixed expectations, then a random program
// checked every cycle against an instruction-level reference model (with a mid-run reset).
module tb_mips16_core;

  logic        clock;
  logic        reset;
  logic [15:0] pc_out;
  logic [15:0] alu_result;
  logic [31:0] instr_out;

  mips16_if bus();

  mips16_core dut (
    .clock      (clock),
    .reset      (reset),
    .pc_out     (pc_out),
    .alu_result (alu_result),
    .instr_out  (instr_out),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rom [256];
  logic [15:0] m_reg [16];
  logic [15:0] m_mem [256];
  logic [15:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
    return {6'h00, rs, rt, rd, 8'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [3:0] rt,
                                        input logic [3:0] rs, input logic [15:0] imm);
    return {op, rs, rt, 2'b00, imm};
  endfunction

  // Architectural effect of one instruction, taken straight from the ISA description.
  task automatic model_eval(input logic [31:0] ins, output logic [15:0] alu,
                            output logic [15:0] nxt, output logic we, output logic [3:0] wa,
                            output logic [15:0] wd, output logic mwe, output logic [7:0] ma,
                            output logic [15:0] md);
    logic [5:0]  op;
    logic [15:0] a, b, imm, res;
    logic        ok;
    op  = ins[31:26];
    a   = m_reg[ins[25:22]];
    b   = m_reg[ins[21:18]];
    imm = ins[15:0];
    alu = 16'd0; nxt = m_pc + 16'd4; we = 1'b0; wa = ins[21:18]; wd = 16'd0;
    mwe = 1'b0; ma = 8'd0; md = 16'd0; res = 16'd0; ok = 1'b1;
    case (op)
      6'h00: begin
        case (ins[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
`ifdef MIPS16_MUL_EN
          6'h18: res = 16'(int'($signed(a)) * int'($signed(b)));
`endif
          default: ok = 1'b0;
        endcase
        if (ok) begin alu = res; we = 1'b1; wa = ins[17:14]; wd = res; end
      end
      6'h08: begin alu = a + imm; we = 1'b1; wd = alu; end
      6'h0C: begin alu = a & imm; we = 1'b1; wd = alu; end
      6'h0D: begin alu = a | imm; we = 1'b1; wd = alu; end
      6'h0A: begin alu = ($signed(a) < $signed(imm)) ? 16'd1 : 16'd0; we = 1'b1; wd = alu; end
      6'h23: begin alu = a + imm; we = 1'b1; wd = m_mem[alu[7:0]]; end
      6'h2B: begin alu = a + imm; mwe = 1'b1; ma = alu[7:0]; md = b; end
      6'h04: begin alu = a - b; if (a == b) nxt = m_pc + 16'd4 + (imm << 2); end
      6'h05: begin alu = a - b; if (a != b) nxt = m_pc + 16'd4 + (imm << 2); end
      6'h02: nxt = imm << 2;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_pc = 16'd0;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'd0;
  endtask

  // Holds reset low while writing the whole ROM image; leaves the bench at a falling edge.
  task automatic load_and_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      bus.load_we   = 1'b1;
      bus.load_addr = 8'(i);
      bus.load_data = m_rom[i];
      @(posedge clock);
      #1;
    end
    bus.load_we = 1'b0;
    @(negedge clock);
  endtask

  // Compare the current cycle against the model, then advance one clock.
  task automatic step(input int k);
    logic [15:0] alu, nxt, wd, md;
    logic        we, mwe;
    logic [3:0]  wa;
    logic [7:0]  ma;
    model_eval(m_rom[m_pc[9:2]], alu, nxt, we, wa, wd, mwe, ma, md);
    check($sformatf("s%0d_pc", k), {16'd0, pc_out}, {16'd0, m_pc});
    check($sformatf("s%0d_instr", k), instr_out, m_rom[m_pc[9:2]]);
    check($sformatf("s%0d_alu", k), {16'd0, alu_result}, {16'd0, alu});
    check($sformatf("s%0d_regwe", k), {31'd0, bus.reg_we}, {31'd0, we});
    check($sformatf("s%0d_memwe", k), {31'd0, bus.mem_we}, {31'd0, mwe});
    @(posedge clock);
    if (we && wa != 4'd0) m_reg[wa] = wd;
    if (mwe) m_mem[ma] = md;
    m_pc = nxt;
    @(negedge clock);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_r%0d", tag, i), {16'd0, dut.reg_file.reg_array[i]}, {16'd0, m_reg[i]});
  endtask

  function automatic logic [31:0] rand_ins();
    logic [3:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    rs  = 4'($urandom_range(0, 15));
    rt  = 4'($urandom_range(0, 15));
    rd  = 4'($urandom_range(0, 15));
    imm = 16'($urandom_range(0, 65535));
    case ($urandom_range(0, 11))
      0, 1: begin
        case ($urandom_range(0, 8))
          0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h26;
          5: fn = 6'h27; 6: fn = 6'h2A; 7: fn = 6'h18;
          default: fn = 6'($urandom_range(0, 63));
        endcase
        return r_ins(fn, rd, rs, rt);
      end
      2: return i_ins(6'h08, rt, rs, imm);
      3: return i_ins(6'h0C, rt, rs, imm);
      4: return i_ins(6'h0D, rt, rs, imm);
      5: return i_ins(6'h0A, rt, rs, imm);
      6: return i_ins(6'h23, rt, rs, imm);
      7: return i_ins(6'h2B, rt, rs, imm);
      8: return i_ins(6'h04, rt, rs, 16'(int'($urandom_range(0, 15)) - 8));
      9: return i_ins(6'h05, rt, rs, 16'(int'($urandom_range(0, 15)) - 8));
      10: return {6'h02, 10'd0, 16'($urandom_range(0, 255))};
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset         = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_addr = 8'd0;
    bus.load_data = 32'd0;

    // Directed program
    for (int i = 0; i < 256; i++) m_rom[i] = 32'd0;
    m_rom[0]  = i_ins(6'h08, 4'd1, 4'd0, 16'd5);
    m_rom[1]  = i_ins(6'h08, 4'd2, 4'd0, 16'hFFFD);
    m_rom[2]  = r_ins(6'h20, 4'd3, 4'd1, 4'd2);
    m_rom[3]  = r_ins(6'h22, 4'd4, 4'd1, 4'd2);
    m_rom[4]  = r_ins(6'h2A, 4'd5, 4'd2, 4'd1);
    m_rom[5]  = i_ins(6'h2B, 4'd1, 4'd0, 16'd4);
    m_rom[6]  = i_ins(6'h23, 4'd6, 4'd0, 16'd4);
    m_rom[7]  = i_ins(6'h08, 4'd0, 4'd0, 16'd7);
    m_rom[8]  = i_ins(6'h04, 4'd1, 4'd1, 16'd2);
    m_rom[9]  = i_ins(6'h08, 4'd8, 4'd0, 16'd1);
    m_rom[10] = i_ins(6'h08, 4'd8, 4'd0, 16'd2);
    m_rom[11] = i_ins(6'h05, 4'd1, 4'd1, 16'd2);
    m_rom[12] = 32'hFC5A_A5A5;
    m_rom[13] = r_ins(6'h18, 4'd7, 4'd1, 4'd2);
    m_rom[14] = {6'h02, 10'd0, 16'h0010};

    load_and_reset();
    check("rst_pc", {16'd0, pc_out}, 32'd0);
    check_regs("rst");
    reset = 1'b1;

    step(0);
    check("addi_r1_pc", {16'd0, pc_out}, 32'h4);
    step(1);
    check("addi_r2_pc", {16'd0, pc_out}, 32'h8);
    check("addi_r1", {16'd0, dut.reg_file.reg_array[1]}, 32'h0005);
    check("addi_r2", {16'd0, dut.reg_file.reg_array[2]}, 32'hFFFD);
    for (int k = 2; k < 5; k++) step(k);
    check("add_r3", {16'd0, dut.reg_file.reg_array[3]}, 32'h0002);
    check("sub_r4", {16'd0, dut.reg_file.reg_array[4]}, 32'h0008);
    check("slt_r5", {16'd0, dut.reg_file.reg_array[5]}, 32'h0001);
    check("sw_alu", {16'd0, alu_result}, 32'h0004);
    step(5);
    check("lw_alu", {16'd0, alu_result}, 32'h0004);
    step(6);
    check("lw_r6", {16'd0, dut.reg_file.reg_array[6]}, 32'h0005);
    step(7);
    check("r0_stays", {16'd0, dut.reg_file.reg_array[0]}, 32'h0);
    step(8);
    check("beq_pc", {16'd0, pc_out}, 32'h002C);
    step(9);
    check("bne_pc", {16'd0, pc_out}, 32'h0030);
    step(10);
    check("unk_pc", {16'd0, pc_out}, 32'h0034);
    step(11);
`ifdef MIPS16_MUL_EN
    check("mul_r7", {16'd0, dut.reg_file.reg_array[7]}, 32'hFFF1);
`else
    check("mul_r7", {16'd0, dut.reg_file.reg_array[7]}, 32'h0000);
`endif
    step(12);
    check("j_pc", {16'd0, pc_out}, 32'h0040);
    check("skip_r8", {16'd0, dut.reg_file.reg_array[8]}, 32'h0);
    check_regs("dir");

    // Random program, with an asynchronous reset in the middle of the run
    for (int i = 0; i < 256; i++) m_rom[i] = rand_ins();
    load_and_reset();
    reset = 1'b1;
    for (int k = 100; k < 300; k++) step(k);
    check_regs("mid");
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_pc", {16'd0, pc_out}, 32'd0);
    check_regs("arst");
    for (int i = 0; i < 256; i++)
      check($sformatf("arst_m%0d", i), {16'd0, dut.dmem_q[i]}, 32'd0);
    #1;
    reset = 1'b1;
    for (int k = 300; k < 500; k++) step(k);
    check_regs("end");
    for (int i = 0; i < 256; i++)
      check($sformatf("end_m%0d", i), {16'd0, dut.dmem_q[i]}, {16'd0, m_mem[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
